// File: rtl/router_pkg.sv
// Shared types and constants for the router input stage.
//   flit_type_e : 2-bit flit type encoding carried alongside every payload
//   vc_state_e  : per-virtual-channel control state
//   DIR_W       : width of a routing direction
package router_pkg;

  localparam int unsigned DIR_W       = 2;
  localparam int unsigned FLIT_TYPE_W = 2;

  typedef enum logic [1:0] {
    HEAD      = 2'b00,
    BODY      = 2'b01,
    TAIL      = 2'b10,
    HEAD_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    ROUTING  = 2'b01,
    VC_ALLOC = 2'b10,
    ACTIVE   = 2'b11
  } vc_state_e;

  // Flit opens a packet.
  function automatic logic is_head(input logic [FLIT_TYPE_W-1:0] t);
    return (t == HEAD) || (t == HEAD_TAIL);
  endfunction

  // Flit closes a packet.
  function automatic logic is_tail(input logic [FLIT_TYPE_W-1:0] t);
    return (t == TAIL) || (t == HEAD_TAIL);
  endfunction

endpackage

// File: rtl/vc_fifo.sv
// Single virtual-channel flit FIFO.
//   clk, rst_n : clock, synchronous active-low reset (empties the FIFO)
//   push, din  : write strobe and data; ignored when full unless popping
//   pop        : remove the head entry; ignored when empty
//   dout       : current head entry (valid while !empty)
//   empty/full : occupancy flags
//   count      : occupancy, 0..DEPTH
module vc_fifo #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 34,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  // Pointer and occupancy update; a full FIFO accepts a write only alongside a pop.
  always_comb begin
    do_pop   = pop && (cnt_q != '0);
    do_push  = push && ((cnt_q != CNT_W'(DEPTH)) || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read behind a valid count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign count = cnt_q;

endmodule

// File: rtl/input_vc_unit.sv
// Per-input-port front end of the virtual-channel router.
//   in_*            : incoming flit (valid, target VC, type, payload)
//   credit_*        : registered credit return, one freed slot per cycle max
//   rc_dest_router  : head destination to route_compute; rc_direction returns same cycle
//   va_req/va_dir   : VC-allocation requests and latched per-VC directions
//   va_grant_*      : VC allocation grant (input VC, downstream VC)
//   sa_req          : switch requests from ACTIVE, non-empty VCs
//   sa_grant_*      : switch grant
//   out_*           : registered dequeued flit toward the crossbar
//   err_overflow/err_protocol : sticky error flags
module input_vc_unit
  import router_pkg::*;
#(
  parameter  int unsigned NUM_VCS         = 4,
  parameter  int unsigned BUFFER_DEPTH    = 4,
  parameter  int unsigned NUM_ROUTERS     = 16,
  parameter  int unsigned FLIT_DATA_WIDTH = 32,
  localparam int unsigned VC_ID_BITS      = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
  localparam int unsigned ROUTER_ID_BITS  = (NUM_ROUTERS > 1) ? $clog2(NUM_ROUTERS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [VC_ID_BITS-1:0]        in_vc,
  input  logic [1:0]                   in_flit_type,
  input  logic [FLIT_DATA_WIDTH-1:0]   in_flit_data,
  output logic                         credit_valid,
  output logic [VC_ID_BITS-1:0]        credit_vc,
  output logic [ROUTER_ID_BITS-1:0]    rc_dest_router,
  input  logic [1:0]                   rc_direction,
  output logic [NUM_VCS-1:0]           va_req,
  output logic [NUM_VCS*2-1:0]         va_dir,
  input  logic                         va_grant_valid,
  input  logic [VC_ID_BITS-1:0]        va_grant_vc,
  input  logic [VC_ID_BITS-1:0]        va_grant_out_vc,
  output logic [NUM_VCS-1:0]           sa_req,
  input  logic                         sa_grant_valid,
  input  logic [VC_ID_BITS-1:0]        sa_grant_vc,
  output logic                         out_valid,
  output logic [1:0]                   out_flit_type,
  output logic [FLIT_DATA_WIDTH-1:0]   out_flit_data,
  output logic [1:0]                   out_dir,
  output logic [VC_ID_BITS-1:0]        out_vc,
  output logic                         err_overflow,
  output logic                         err_protocol
);

  localparam int unsigned FW    = FLIT_TYPE_W + FLIT_DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(BUFFER_DEPTH + 1);

  // Per-VC control state
  vc_state_e             state_q [NUM_VCS];
  vc_state_e             state_d [NUM_VCS];
  logic [DIR_W-1:0]      dir_q   [NUM_VCS];
  logic [DIR_W-1:0]      dir_d   [NUM_VCS];
  logic [VC_ID_BITS-1:0] ovc_q   [NUM_VCS];
  logic [VC_ID_BITS-1:0] ovc_d   [NUM_VCS];
  logic [VC_ID_BITS-1:0] rr_q, rr_d;

  // Registered outputs
  logic                       credit_valid_q, credit_valid_d;
  logic [VC_ID_BITS-1:0]      credit_vc_q, credit_vc_d;
  logic                       out_valid_q, out_valid_d;
  logic [1:0]                 out_type_q, out_type_d;
  logic [FLIT_DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [DIR_W-1:0]           out_dir_q, out_dir_d;
  logic [VC_ID_BITS-1:0]      out_vc_q, out_vc_d;
  logic                       err_ovf_q, err_ovf_d;
  logic                       err_prot_q, err_prot_d;

  // FIFO interface
  logic [NUM_VCS-1:0] push, pop, empty, full;
  logic [FW-1:0]      dout  [NUM_VCS];
  logic [CNT_W-1:0]   count [NUM_VCS];
  logic               unused_count;

  // Arbitration results
  logic                  sa_hit, pe_hit, rc_found;
  logic [VC_ID_BITS-1:0] sa_vc, pe_vc, rc_sel;
  int unsigned           rc_idx;

  for (genvar g = 0; g < NUM_VCS; g++) begin : g_fifo
    vc_fifo #(
      .DEPTH (BUFFER_DEPTH),
      .WIDTH (FW)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[g]),
      .pop   (pop[g]),
      .din   ({in_flit_type, in_flit_data}),
      .dout  (dout[g]),
      .empty (empty[g]),
      .full  (full[g]),
      .count (count[g])
    );
  end

  // Occupancy is tracked through empty/full; count is only observed.
  always_comb begin
    unused_count = 1'b0;
    for (int unsigned v = 0; v < NUM_VCS; v++) unused_count = unused_count ^ (^count[v]);
  end

  // Allocator-facing request and direction vectors.
  always_comb begin
    va_req = '0;
    sa_req = '0;
    va_dir = '0;
    for (int unsigned v = 0; v < NUM_VCS; v++) begin
      va_req[v] = (state_q[v] == VC_ALLOC);
      sa_req[v] = (state_q[v] == ACTIVE) && !empty[v];
      va_dir[v*DIR_W +: DIR_W] = dir_q[v];
    end
  end

  // Pop sources: a valid switch grant wins; otherwise the lowest IDLE VC with a stray BODY/TAIL.
  always_comb begin
    sa_hit = 1'b0;
    sa_vc  = '0;
    pe_hit = 1'b0;
    pe_vc  = '0;
    for (int unsigned v = 0; v < NUM_VCS; v++) begin
      if (sa_grant_valid && (sa_grant_vc == VC_ID_BITS'(v)) && sa_req[v]) begin
        sa_hit = 1'b1;
        sa_vc  = VC_ID_BITS'(v);
      end
      if (!pe_hit && (state_q[v] == IDLE) && !empty[v] &&
          !is_head(dout[v][FW-1 -: FLIT_TYPE_W])) begin
        pe_hit = 1'b1;
        pe_vc  = VC_ID_BITS'(v);
      end
    end
  end

  // Round-robin pick of one ROUTING VC starting at rr_q.
  always_comb begin
    rc_found = 1'b0;
    rc_sel   = '0;
    rc_idx   = 0;
    for (int unsigned i = 0; i < NUM_VCS; i++) begin
      rc_idx = (int'(rr_q) + i) % NUM_VCS;
      if (!rc_found && (state_q[rc_idx] == ROUTING)) begin
        rc_found = 1'b1;
        rc_sel   = VC_ID_BITS'(rc_idx);
      end
    end
  end

  assign rc_dest_router = rc_found ? dout[rc_sel][ROUTER_ID_BITS-1:0] : '0;

  // Next-state for VC FSMs, FIFO strobes and registered outputs.
  always_comb begin
    state_d        = state_q;
    dir_d          = dir_q;
    ovc_d          = ovc_q;
    rr_d           = rr_q;
    push           = '0;
    pop            = '0;
    credit_valid_d = 1'b0;
    credit_vc_d    = '0;
    out_valid_d    = 1'b0;
    out_type_d     = '0;
    out_data_d     = '0;
    out_dir_d      = '0;
    out_vc_d       = '0;
    err_ovf_d      = err_ovf_q;
    err_prot_d     = err_prot_q;

    if (sa_hit) begin
      pop[sa_vc]     = 1'b1;
      credit_valid_d = 1'b1;
      credit_vc_d    = sa_vc;
      out_valid_d    = 1'b1;
      out_type_d     = dout[sa_vc][FW-1 -: FLIT_TYPE_W];
      out_data_d     = dout[sa_vc][FLIT_DATA_WIDTH-1:0];
      out_dir_d      = dir_q[sa_vc];
      out_vc_d       = ovc_q[sa_vc];
    end else if (pe_hit) begin
      pop[pe_vc]     = 1'b1;
      credit_valid_d = 1'b1;
      credit_vc_d    = pe_vc;
      err_prot_d     = 1'b1;
    end

    if (rc_found) rr_d = VC_ID_BITS'((int'(rc_sel) + 1) % NUM_VCS);

    for (int unsigned v = 0; v < NUM_VCS; v++) begin
      if (in_valid && (in_vc == VC_ID_BITS'(v))) begin
        if (!full[v] || pop[v]) push[v]   = 1'b1;
        else                    err_ovf_d = 1'b1;
      end

      case (state_q[v])
        IDLE: begin
          // An empty VC looks at the incoming flit so a fresh head routes next cycle.
          if (!empty[v]) begin
            if (is_head(dout[v][FW-1 -: FLIT_TYPE_W])) state_d[v] = ROUTING;
          end else if (in_valid && (in_vc == VC_ID_BITS'(v)) && is_head(in_flit_type)) begin
            state_d[v] = ROUTING;
          end
        end
        ROUTING: begin
          if (rc_found && (rc_sel == VC_ID_BITS'(v))) begin
            dir_d[v]   = rc_direction;
            state_d[v] = VC_ALLOC;
          end
        end
        VC_ALLOC: begin
          if (va_grant_valid && (va_grant_vc == VC_ID_BITS'(v))) begin
            ovc_d[v]   = va_grant_out_vc;
            state_d[v] = ACTIVE;
          end
        end
        ACTIVE: begin
          if (sa_hit && (sa_vc == VC_ID_BITS'(v)) && is_tail(dout[v][FW-1 -: FLIT_TYPE_W]))
            state_d[v] = IDLE;
        end
        default: state_d[v] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned v = 0; v < NUM_VCS; v++) begin
        state_q[v] <= IDLE;
        dir_q[v]   <= '0;
        ovc_q[v]   <= '0;
      end
      rr_q           <= '0;
      credit_valid_q <= 1'b0;
      credit_vc_q    <= '0;
      out_valid_q    <= 1'b0;
      out_type_q     <= '0;
      out_data_q     <= '0;
      out_dir_q      <= '0;
      out_vc_q       <= '0;
      err_ovf_q      <= 1'b0;
      err_prot_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      dir_q          <= dir_d;
      ovc_q          <= ovc_d;
      rr_q           <= rr_d;
      credit_valid_q <= credit_valid_d;
      credit_vc_q    <= credit_vc_d;
      out_valid_q    <= out_valid_d;
      out_type_q     <= out_type_d;
      out_data_q     <= out_data_d;
      out_dir_q      <= out_dir_d;
      out_vc_q       <= out_vc_d;
      err_ovf_q      <= err_ovf_d;
      err_prot_q     <= err_prot_d;
    end
  end

  assign credit_valid  = credit_valid_q;
  assign credit_vc     = credit_vc_q;
  assign out_valid     = out_valid_q;
  assign out_flit_type = out_type_q;
  assign out_flit_data = out_data_q;
  assign out_dir       = out_dir_q;
  assign out_vc        = out_vc_q;
  assign err_overflow  = err_ovf_q;
  assign err_protocol  = err_prot_q;

endmodule
